riscv_gpr_wb_arbiter: RTL and testbench

RISCV_GPR_WB_ARBITER -- requirements
Module: riscv_gpr_wb_arbiter

---
 rtl/riscv_gpr_wb_arbiter.sv | 140 ++++++++++++++
 tb/tb_riscv_gpr_wb_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_gpr_wb_arbiter.sv
// riscv_gpr_wb_arbiter
// Arbitrates GPR write-back requests from ALU, LSU and MUL/DIV onto the
// single register-file write port. Round-robin or fixed priority, one
// handshake per cycle, one-cycle registered write latency, per-requester
// starvation monitoring with a sticky error flag.
module riscv_gpr_wb_arbiter #(
    parameter int          XLEN         = 32,
    parameter bit          RR_EN        = 1'b1,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [2:0]          req_valid,
    output logic [2:0]          req_ready,
    input  logic [14:0]         req_dest,
    input  logic [3*XLEN-1:0]   req_data,
    input  logic                wb_hold,
    output logic                reg_write_en,
    output logic [4:0]          reg_write_dest,
    output logic [XLEN-1:0]     reg_write_data,
    output logic [1:0]          wb_src,
    output logic                err_starve
);

    logic [1:0]      last_grant;
    logic [2:0]      grant;
    logic [1:0]      grant_idx;
    logic [1:0]      cand;
    logic            handshake;
    logic [4:0]      sel_dest;
    logic [XLEN-1:0] sel_data;
    logic [7:0]      wait_cnt [3];
    logic            any_starved;

    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // Grant selection: at most one requester, nothing while held or in reset
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        cand      = next_idx(last_grant);
        if (rst_n && !wb_hold) begin
            if (RR_EN) begin
                for (int unsigned k = 0; k < 3; k++) begin
                    if (grant == '0 && req_valid[cand]) begin
                        grant[cand] = 1'b1;
                        grant_idx   = cand;
                    end
                    cand = next_idx(cand);
                end
            end else begin
                for (int unsigned i = 0; i < 3; i++) begin
                    if (grant == '0 && req_valid[i]) begin
                        grant[i]  = 1'b1;
                        grant_idx = 2'(i);
                    end
                end
            end
        end
    end

    assign req_ready = grant;
    assign handshake = |(grant & req_valid);

    // Select the granted requester's destination and data
    always_comb begin
        sel_dest = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            if (grant[i]) begin
                sel_dest = req_dest[5*i +: 5];
                sel_data = req_data[XLEN*i +: XLEN];
            end
        end
    end

    // Register the accepted write; x0 completes the handshake but never writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write_en   <= 1'b0;
            reg_write_dest <= '0;
            reg_write_data <= '0;
            wb_src         <= '0;
        end else begin
            reg_write_en <= handshake && (sel_dest != '0);
            if (handshake) begin
                reg_write_dest <= sel_dest;
                reg_write_data <= sel_data;
                wb_src         <= grant_idx;
            end
        end
    end

    // Round-robin pointer; reset value 2 makes requester 0 first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 2'd2;
        end else if (handshake) begin
            last_grant <= grant_idx;
        end
    end

    // Saturating per-requester wait counters, frozen while write-back is held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 3; i++) begin
                wait_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                if (!req_valid[i] || grant[i]) begin
                    wait_cnt[i] <= '0;
                end else if (!wb_hold && wait_cnt[i] != '1) begin
                    wait_cnt[i] <= wait_cnt[i] + 8'd1;
                end
            end
        end
    end

    always_comb begin
        any_starved = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            if (32'(wait_cnt[i]) >= STARVE_LIMIT) begin
                any_starved = 1'b1;
            end
        end
    end

    // Sticky starvation flag, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_starve <= 1'b0;
        end else if (any_starved) begin
            err_starve <= 1'b1;
        end
    end

endmodule

// File: tb/tb_riscv_gpr_wb_arbiter.sv
// Self-checking bench for riscv_gpr_wb_arbiter: a round-robin and a
// fixed-priority instance, a reference model of arbitration and starvation,
// and a write-back scoreboard queue per instance.
module tb_riscv_gpr_wb_arbiter;

    typedef struct packed {
        logic        en;
        logic [4:0]  dest;
        logic [31:0] data;
        logic [1:0]  src;
    } wb_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  rr_valid, fp_valid;
    logic [14:0] req_dest;
    logic [95:0] req_data;
    logic        wb_hold;

    logic [2:0]  rr_ready, fp_ready;
    logic        rr_en, fp_en;
    logic [4:0]  rr_dest, fp_dest;
    logic [31:0] rr_data, fp_data;
    logic [1:0]  rr_src, fp_src;
    logic        rr_err, fp_err;

    int n_checks = 0;
    int n_fail   = 0;
    int fp_g2    = 0;

    wb_t sbq0[$];
    wb_t sbq1[$];

    logic [1:0]  lg_m    [2];
    int          cnt_m   [2][3];
    logic        err_m   [2];
    logic [4:0]  hd_dest [2];
    logic [31:0] hd_data [2];
    logic [1:0]  hd_src  [2];

    always #5 clk = ~clk;

    riscv_gpr_wb_arbiter #(.XLEN(32), .RR_EN(1'b1), .STARVE_LIMIT(8)) u_rr (
        .clk(clk), .rst_n(rst_n), .req_valid(rr_valid), .req_ready(rr_ready),
        .req_dest(req_dest), .req_data(req_data), .wb_hold(wb_hold),
        .reg_write_en(rr_en), .reg_write_dest(rr_dest), .reg_write_data(rr_data),
        .wb_src(rr_src), .err_starve(rr_err)
    );

    riscv_gpr_wb_arbiter #(.XLEN(32), .RR_EN(1'b0), .STARVE_LIMIT(8)) u_fp (
        .clk(clk), .rst_n(rst_n), .req_valid(fp_valid), .req_ready(fp_ready),
        .req_dest(req_dest), .req_data(req_data), .wb_hold(wb_hold),
        .reg_write_en(fp_en), .reg_write_dest(fp_dest), .reg_write_data(fp_data),
        .wb_src(fp_src), .err_starve(fp_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Monitor and reference model, evaluated mid-cycle while inputs are stable
    always @(negedge clk) begin : monitor
        logic [2:0]  v, rdy, eg;
        logic        en, err, have;
        logic [4:0]  dst;
        logic [31:0] dat;
        logic [1:0]  src, c;
        int          gi;
        string       nm;
        wb_t         e;
        for (int d = 0; d < 2; d++) begin
            if (d == 0) begin
                v = rr_valid; rdy = rr_ready; en = rr_en; dst = rr_dest;
                dat = rr_data; src = rr_src; err = rr_err; nm = "rr";
            end else begin
                v = fp_valid; rdy = fp_ready; en = fp_en; dst = fp_dest;
                dat = fp_data; src = fp_src; err = fp_err; nm = "fp";
            end
            if (!rst_n) begin
                check({nm, "_rst_ready"}, 64'(rdy), 64'd0);
                check({nm, "_rst_out"}, {en, dst, dat, src, err}, 64'd0);
                lg_m[d] = 2'd2; err_m[d] = 1'b0;
                hd_dest[d] = '0; hd_data[d] = '0; hd_src[d] = '0;
                for (int i = 0; i < 3; i++) cnt_m[d][i] = 0;
                if (d == 0) sbq0.delete(); else sbq1.delete();
            end else begin
                // scoreboard: output write corresponds to last cycle's handshake
                have = 1'b0;
                e = '0;
                if (d == 0 && sbq0.size() > 0) begin have = 1'b1; e = sbq0.pop_front(); end
                if (d == 1 && sbq1.size() > 0) begin have = 1'b1; e = sbq1.pop_front(); end
                if (have) begin
                    hd_dest[d] = e.dest; hd_data[d] = e.data; hd_src[d] = e.src;
                end
                check({nm, "_wb_en"}, 64'(en), 64'(have && e.en));
                check({nm, "_wb_dest"}, 64'(dst), 64'(hd_dest[d]));
                check({nm, "_wb_data"}, 64'(dat), 64'(hd_data[d]));
                check({nm, "_wb_src"}, 64'(src), 64'(hd_src[d]));
                check({nm, "_err_starve"}, 64'(err), 64'(err_m[d]));

                // expected grant for this cycle
                eg = '0;
                gi = 0;
                if (!wb_hold) begin
                    if (d == 0) begin
                        c = lg_m[d];
                        for (int k = 0; k < 3; k++) begin
                            c = (c == 2'd2) ? 2'd0 : c + 2'd1;
                            if (eg == '0 && v[c]) begin eg[c] = 1'b1; gi = int'(c); end
                        end
                    end else begin
                        for (int i = 2; i >= 0; i--) begin
                            if (v[i]) begin eg = '0; eg[i] = 1'b1; gi = i; end
                        end
                    end
                end
                check({nm, "_req_ready"}, 64'(rdy), 64'(eg));
                if (d == 1 && rdy[2]) fp_g2++;

                if (eg != '0) begin
                    e.dest = req_dest[gi*5 +: 5];
                    e.data = req_data[gi*32 +: 32];
                    e.src  = 2'(gi);
                    e.en   = (e.dest != 5'd0);
                    if (d == 0) sbq0.push_back(e); else sbq1.push_back(e);
                    lg_m[d] = 2'(gi);
                end

                for (int i = 0; i < 3; i++) begin
                    if (cnt_m[d][i] >= 8) err_m[d] = 1'b1;
                end
                for (int i = 0; i < 3; i++) begin
                    if (!v[i] || eg[i]) cnt_m[d][i] = 0;
                    else if (!wb_hold && cnt_m[d][i] < 255) cnt_m[d][i]++;
                end
            end
        end
    end

    task automatic drive(input logic [2:0] rv, input logic [2:0] fv, input logic hold);
        rr_valid = rv;
        fp_valid = fv;
        wb_hold  = hold;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        drive(3'b000, 3'b000, 1'b0);
        req_dest = '0;
        req_data = '0;
        step(3);
        rst_n = 1'b1;

        // all three valid continuously: grants 0,1,2,0,1,2
        req_dest = {5'd3, 5'd2, 5'd1};
        req_data = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001};
        drive(3'b111, 3'b000, 1'b0);
        step(6);
        drive(3'b000, 3'b000, 1'b0);
        step(2);

        // single ALU request, dest 5, data 0xAA
        req_dest = {5'd3, 5'd2, 5'd5};
        req_data = {32'h3333_0003, 32'h2222_0002, 32'h0000_00AA};
        drive(3'b001, 3'b000, 1'b0);
        step(1);
        drive(3'b000, 3'b000, 1'b0);
        step(2);

        // LSU to x0: handshake, no write enable
        req_dest = {5'd3, 5'd0, 5'd1};
        req_data = {32'h3333_0003, 32'hFFFF_FFFF, 32'h1111_0001};
        drive(3'b010, 3'b000, 1'b0);
        step(1);
        drive(3'b000, 3'b000, 1'b0);
        step(2);

        // handshake then hold: pending write still lands, then 5 held cycles
        req_dest = {5'd12, 5'd11, 5'd10};
        req_data = {32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};
        drive(3'b111, 3'b000, 1'b0);
        step(1);
        drive(3'b111, 3'b000, 1'b1);
        step(5);
        drive(3'b111, 3'b000, 1'b0);
        step(3);
        drive(3'b000, 3'b000, 1'b0);
        step(2);

        // same dest from ALU then LSU, round-robin from reset
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        req_dest = {5'd0, 5'd7, 5'd7};
        req_data = {32'h0, 32'h0000_0022, 32'h0000_0011};
        drive(3'b011, 3'b000, 1'b0);
        step(1);
        drive(3'b010, 3'b000, 1'b0);
        step(1);
        drive(3'b000, 3'b000, 1'b0);
        step(2);

        // repeat, pulling reset low while the second write is on the outputs
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        drive(3'b011, 3'b000, 1'b0);
        step(1);
        drive(3'b010, 3'b000, 1'b0);
        step(1);
        check("pre_rst_write", {rr_en, rr_dest, rr_data}, {1'b1, 5'd7, 32'h22});
        rst_n = 1'b0;
        drive(3'b000, 3'b000, 1'b0);
        #1;
        check("async_rst_out", {rr_en, rr_dest, rr_data, rr_src}, 64'd0);
        check("async_rst_ready", 64'(rr_ready), 64'd0);
        step(2);
        rst_n = 1'b1;
        step(3);

        // fixed priority: req 0 and req 2 held valid, hold in the middle
        req_dest = {5'd10, 5'd0, 5'd9};
        req_data = {32'hBEEF_0002, 32'h0, 32'hBEEF_0000};
        drive(3'b000, 3'b101, 1'b0);
        step(5);
        drive(3'b000, 3'b101, 1'b1);
        step(5);
        check("fp_err_before_limit", 64'(fp_err), 64'd0);
        drive(3'b000, 3'b101, 1'b0);
        step(5);
        drive(3'b000, 3'b000, 1'b0);
        step(2);

        check("fp_err_final", 64'(fp_err), 64'd1);
        check("rr_err_final", 64'(rr_err), 64'd0);
        check("fp_req2_grants", 64'(fp_g2), 64'd0);
        check("sb_drain", 64'(sbq0.size() + sbq1.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
